xc_malu_issue: RTL and testbench
================================

XC_MALU_ISSUE -- requirements
Module: xc_malu_issue

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req_valid  in  1  request offered; req_ready  out  1  request accepted when both high at a clock edge.
REQ-005 req_op  in  3  0=div, 1=rem, 2=mul, 3=pmul, 4=madd, 5=msub, 6=macc, 7=illegal.
REQ-006 req_lh_sign, req_rh_sign, req_carryless  in  1 each  operand signedness / carryless modifier.
REQ-007 req_pw  in  3  0=32, 1=16, 2=8, 3=4, 4=2, 5-7 illegal.
REQ-008 req_rs1, req_rs2, req_rs3  in  32 each  operands.
REQ-009 m_valid  out  1; m_ready  in  1; m_flush  out  1: MALU handshake.
REQ-010 m_rs1, m_rs2, m_rs3  out  32 each: operands to MALU.
REQ-011 m_uop_div, m_uop_rem, m_uop_mul, m_uop_pmul, m_uop_madd, m_uop_msub_1, m_uop_msub_2, m_uop_macc_1, m_uop_macc_2  out  1 each: one-hot uop.
REQ-012 m_mod_lh_sign, m_mod_rh_sign, m_mod_carryless  out  1 each.
REQ-013 m_pw_32, m_pw_16, m_pw_8, m_pw_4, m_pw_2  out  1 each: one-hot width.
REQ-014 m_result  in  64: MALU result, valid when m_valid and m_ready.
REQ-015 rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  64; rsp_error  out  1.

Function
REQ-016 FSM states IDLE, ISSUE1, ISSUE2, RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 IDLE, req accepted, legal -> ISSUE1 next cycle; op, modifiers, rs1-rs3 registered at acceptance.
REQ-018 IDLE, req accepted, illegal (op=7, or pw>=5) -> RESP next cycle, rsp_result=0, rsp_error=1; no MALU issue.
REQ-019 m_valid SHALL be 1 exactly in ISSUE1 and ISSUE2; m_rs*, m_uop_*, m_mod_*, m_pw_* SHALL be registered and stable while m_valid=1 and m_ready=0.
REQ-020 m_flush SHALL equal m_valid AND m_ready (combinational).
REQ-021 Uop mapping in ISSUE1: div->div, rem->rem, mul->mul, pmul->pmul, madd->madd, msub->msub_1, macc->macc_1; ISSUE2: msub->msub_2, macc->macc_2; exactly one m_uop_* high when m_valid=1, all zero otherwise.
REQ-022 ISSUE1 + m_ready: single-uop ops -> RESP; msub/macc -> ISSUE2 (same registered operands).
REQ-023 ISSUE2 + m_ready -> RESP.
REQ-024 rsp_result SHALL capture m_result on the final MALU handshake; first-uop result of msub/macc discarded.
REQ-025 Width rule: non-pmul ops SHALL drive m_pw_32=1 regardless of req_pw; pmul with req_pw=0 is illegal (REQ-018 response).
REQ-026 Sign rule: m_mod_carryless=1 forces m_mod_lh_sign=m_mod_rh_sign=0; div/rem drive m_mod_rh_sign=m_mod_lh_sign=req_lh_sign; carryless forced 0 for div/rem/madd/msub/macc.
REQ-027 rsp_valid SHALL be 1 exactly in RESP; rsp_result/rsp_error stable while rsp_valid=1 and rsp_ready=0.
REQ-028 RESP + rsp_ready -> IDLE; no request accepted in the same cycle (req_ready=0 in RESP).
REQ-029 Minimum latency, single-uop, m_ready tied 1: request accepted edge N, MALU handshake edge N+1, rsp_valid high cycle after N+1.
REQ-030 m_ready high while m_valid=0 SHALL be ignored.

Reset
REQ-031 reset=1 at clock edge -> state IDLE; m_valid, rsp_valid, rsp_error=0; rsp_result=0; all m_uop_*, m_mod_*, m_pw_*=0; m_rs*=0.
REQ-032 reset mid-operation (any state) SHALL abandon the operation with no response; MALU sees m_valid drop without m_flush.
REQ-033 req_ready SHALL be 0 during reset and 1 the cycle after reset deasserts.

Verification
REQ-034 mul, lh=rh=1, rs1=0xFFFFFFFF, rs2=2, m_ready=1, MALU model -> one uop_mul issue, rsp_result=0xFFFFFFFFFFFFFFFE, rsp_error=0.
REQ-035 macc, m_ready delayed 3 cycles per uop -> macc_1 then macc_2 issued, operands stable throughout stalls, rsp_result = second m_result.
REQ-036 op=7 or pmul pw=0 -> no m_valid, rsp_valid next cycle with rsp_error=1, rsp_result=0.
REQ-037 div with req_rh_sign=0, req_lh_sign=1 -> m_mod_rh_sign=1; mul carryless=1 lh_sign=1 -> m_mod_lh_sign=0.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_valid/result stable, req_ready=0; then 1 -> IDLE, next request accepted following cycle.
REQ-039 reset asserted in ISSUE2 -> all outputs at reset values next cycle, no response, next request processed normally.

Source files
------------

// File: rtl/xc_malu_issue.sv
// xc_malu_issue: accepts one multiply/divide request at a time, decodes it into
// one or two MALU micro-ops, issues them with a valid/ready handshake and
// returns the final MALU result (or an error for illegal encodings).
module xc_malu_issue (
  input  logic        clock,
  input  logic        reset,
  // request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_lh_sign,
  input  logic        req_rh_sign,
  input  logic        req_carryless,
  input  logic [2:0]  req_pw,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  // MALU side
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_flush,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  output logic [31:0] m_rs3,
  output logic        m_uop_div,
  output logic        m_uop_rem,
  output logic        m_uop_mul,
  output logic        m_uop_pmul,
  output logic        m_uop_madd,
  output logic        m_uop_msub_1,
  output logic        m_uop_msub_2,
  output logic        m_uop_macc_1,
  output logic        m_uop_macc_2,
  output logic        m_mod_lh_sign,
  output logic        m_mod_rh_sign,
  output logic        m_mod_carryless,
  output logic        m_pw_32,
  output logic        m_pw_16,
  output logic        m_pw_8,
  output logic        m_pw_4,
  output logic        m_pw_2,
  input  logic [63:0] m_result,
  // response side
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_result,
  output logic        rsp_error
);

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2, RESP} state_t;

  localparam logic [2:0] OP_DIV  = 3'd0;
  localparam logic [2:0] OP_REM  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_PMUL = 3'd3;
  localparam logic [2:0] OP_MADD = 3'd4;
  localparam logic [2:0] OP_MSUB = 3'd5;
  localparam logic [2:0] OP_MACC = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  // uop vector bit order: {div,rem,mul,pmul,madd,msub_1,msub_2,macc_1,macc_2}
  localparam int U_DIV = 8, U_REM = 7, U_MUL = 6, U_PMUL = 5, U_MADD = 4;
  localparam int U_MSUB1 = 3, U_MSUB2 = 2, U_MACC1 = 1, U_MACC2 = 0;

  state_t      state;
  logic [8:0]  uop_q;
  logic [8:0]  uop2_q;   // second uop for two-step ops, zero otherwise
  logic [2:0]  mod_q;    // {lh_sign, rh_sign, carryless}
  logic [4:0]  pw_q;     // {32,16,8,4,2}

  logic        d_illegal;
  logic        d_cl, d_lh, d_rh;
  logic [4:0]  d_pw;
  logic [8:0]  d_uop1, d_uop2;
  logic        last_hs;

  assign req_ready = (state == IDLE) && !reset;
  assign m_flush   = m_valid & m_ready;

  assign {m_uop_div, m_uop_rem, m_uop_mul, m_uop_pmul, m_uop_madd,
          m_uop_msub_1, m_uop_msub_2, m_uop_macc_1, m_uop_macc_2} = uop_q;
  assign {m_mod_lh_sign, m_mod_rh_sign, m_mod_carryless} = mod_q;
  assign {m_pw_32, m_pw_16, m_pw_8, m_pw_4, m_pw_2} = pw_q;

  // Decode the incoming request into uops, modifiers and width.
  always_comb begin
    d_illegal = (req_op == OP_ILL) || (req_pw > 3'd4) ||
                ((req_op == OP_PMUL) && (req_pw == 3'd0));
    // carryless only means something for the multiply family
    d_cl = req_carryless && ((req_op == OP_MUL) || (req_op == OP_PMUL));
    d_lh = req_lh_sign && !d_cl;
    // div/rem have a single signedness, taken from the lh flag
    d_rh = ((req_op == OP_DIV) || (req_op == OP_REM)) ? (req_lh_sign && !d_cl)
                                                      : (req_rh_sign && !d_cl);
    d_pw = (req_op == OP_PMUL) ? (5'b10000 >> req_pw) : 5'b10000;
    d_uop1 = '0;
    d_uop2 = '0;
    case (req_op)
      OP_DIV:  d_uop1[U_DIV]  = 1'b1;
      OP_REM:  d_uop1[U_REM]  = 1'b1;
      OP_MUL:  d_uop1[U_MUL]  = 1'b1;
      OP_PMUL: d_uop1[U_PMUL] = 1'b1;
      OP_MADD: d_uop1[U_MADD] = 1'b1;
      OP_MSUB: begin d_uop1[U_MSUB1] = 1'b1; d_uop2[U_MSUB2] = 1'b1; end
      OP_MACC: begin d_uop1[U_MACC1] = 1'b1; d_uop2[U_MACC2] = 1'b1; end
      default: ;
    endcase
  end

  // Final MALU handshake of the current operation.
  always_comb begin
    last_hs = m_ready && (((state == ISSUE1) && (uop2_q == '0)) || (state == ISSUE2));
  end

  // Issue FSM with registered MALU and response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_rs1      <= '0;
      m_rs2      <= '0;
      m_rs3      <= '0;
      uop_q      <= '0;
      uop2_q     <= '0;
      mod_q      <= '0;
      pw_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (d_illegal) begin
              state      <= RESP;
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_error  <= 1'b1;
            end else begin
              state   <= ISSUE1;
              m_valid <= 1'b1;
              m_rs1   <= req_rs1;
              m_rs2   <= req_rs2;
              m_rs3   <= req_rs3;
              uop_q   <= d_uop1;
              uop2_q  <= d_uop2;
              mod_q   <= {d_lh, d_rh, d_cl};
              pw_q    <= d_pw;
            end
          end
        end
        ISSUE1, ISSUE2: begin
          if (last_hs) begin
            state      <= RESP;
            m_valid    <= 1'b0;
            uop_q      <= '0;
            mod_q      <= '0;
            pw_q       <= '0;
            rsp_valid  <= 1'b1;
            rsp_result <= m_result;
            rsp_error  <= 1'b0;
          end else if (m_ready) begin
            // first half of msub/macc done; its result is not kept
            state <= ISSUE2;
            uop_q <= uop2_q;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xc_malu_issue.sv
// Directed bench for xc_malu_issue with a small behavioural MALU stub.
module tb_xc_malu_issue;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op, req_pw;
  logic        req_lh_sign, req_rh_sign, req_carryless;
  logic [31:0] req_rs1, req_rs2, req_rs3;
  logic        m_valid, m_ready, m_flush;
  logic [31:0] m_rs1, m_rs2, m_rs3;
  logic        m_uop_div, m_uop_rem, m_uop_mul, m_uop_pmul, m_uop_madd;
  logic        m_uop_msub_1, m_uop_msub_2, m_uop_macc_1, m_uop_macc_2;
  logic        m_mod_lh_sign, m_mod_rh_sign, m_mod_carryless;
  logic        m_pw_32, m_pw_16, m_pw_8, m_pw_4, m_pw_2;
  logic [63:0] m_result;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [63:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;

  logic [8:0] uop;
  logic [2:0] mods;
  logic [4:0] pw;
  assign uop  = {m_uop_div, m_uop_rem, m_uop_mul, m_uop_pmul, m_uop_madd,
                 m_uop_msub_1, m_uop_msub_2, m_uop_macc_1, m_uop_macc_2};
  assign mods = {m_mod_lh_sign, m_mod_rh_sign, m_mod_carryless};
  assign pw   = {m_pw_32, m_pw_16, m_pw_8, m_pw_4, m_pw_2};

  always #5 clock = ~clock;

  xc_malu_issue dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_lh_sign(req_lh_sign), .req_rh_sign(req_rh_sign), .req_carryless(req_carryless),
    .req_pw(req_pw), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .m_valid(m_valid), .m_ready(m_ready), .m_flush(m_flush),
    .m_rs1(m_rs1), .m_rs2(m_rs2), .m_rs3(m_rs3),
    .m_uop_div(m_uop_div), .m_uop_rem(m_uop_rem), .m_uop_mul(m_uop_mul),
    .m_uop_pmul(m_uop_pmul), .m_uop_madd(m_uop_madd),
    .m_uop_msub_1(m_uop_msub_1), .m_uop_msub_2(m_uop_msub_2),
    .m_uop_macc_1(m_uop_macc_1), .m_uop_macc_2(m_uop_macc_2),
    .m_mod_lh_sign(m_mod_lh_sign), .m_mod_rh_sign(m_mod_rh_sign),
    .m_mod_carryless(m_mod_carryless),
    .m_pw_32(m_pw_32), .m_pw_16(m_pw_16), .m_pw_8(m_pw_8), .m_pw_4(m_pw_4), .m_pw_2(m_pw_2),
    .m_result(m_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_error(rsp_error)
  );

  // MALU stub: real product for mul, recognisable constants for the rest
  logic signed [32:0] ma, mb;
  logic signed [65:0] mp;
  always_comb begin
    ma = $signed({m_mod_lh_sign & m_rs1[31], m_rs1});
    mb = $signed({m_mod_rh_sign & m_rs2[31], m_rs2});
    mp = ma * mb;
    m_result = 64'h0;
    if (m_uop_mul)         m_result = mp[63:0];
    else if (m_uop_div)    m_result = {32'h0, m_rs1 / m_rs2};
    else if (m_uop_pmul)   m_result = 64'h55;
    else if (m_uop_macc_1 || m_uop_msub_1) m_result = 64'h0000_0000_AAAA_0001;
    else if (m_uop_macc_2 || m_uop_msub_2) m_result = {m_rs3, m_rs1};
  end

  // count MALU handshakes
  always @(posedge clock) if (!reset && m_valid && m_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic lh, input logic rh, input logic cl,
                         input logic [2:0] p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c);
    req_valid = 1'b1; req_op = op; req_lh_sign = lh; req_rh_sign = rh;
    req_carryless = cl; req_pw = p; req_rs1 = a; req_rs2 = b; req_rs3 = c;
  endtask

  task automatic drain();
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask

  int h0;

  initial begin
    reset = 1'b1; req_valid = 1'b0; m_ready = 1'b0; rsp_ready = 1'b0;
    set_req(3'd0, 0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0); req_valid = 1'b0;
    tick(); tick();
    // reset state
    chk("rst_req_ready", req_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_rsp", {rsp_valid, rsp_error, rsp_result}, 0);
    chk("rst_m_fields", {uop, mods, pw, m_rs1, m_rs2}, 0);
    reset = 1'b0; tick();
    chk("rst_release_ready", req_ready, 1);

    // mul signed: -1 * 2, m_ready tied high (also high while idle)
    m_ready = 1'b1; h0 = hs_cnt;
    set_req(3'd2, 1, 1, 0, 3'd3, 32'hFFFF_FFFF, 32'd2, 32'd0);
    tick(); req_valid = 1'b0;
    chk("mul_m_valid", m_valid, 1);
    chk("mul_uop", uop, 9'b001000000);
    chk("mul_mods", mods, 3'b110);
    chk("mul_pw", pw, 5'b10000);
    chk("mul_flush", m_flush, 1);
    chk("mul_req_ready", req_ready, 0);
    tick();
    chk("mul_rsp_valid", {m_valid, rsp_valid}, 2'b01);
    chk("mul_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mul_error", rsp_error, 0);
    chk("mul_hs_cnt", hs_cnt - h0, 1);
    drain();
    chk("mul_back_idle", {rsp_valid, req_ready}, 2'b01);

    // macc with 3-cycle stalls on each uop
    m_ready = 1'b0; h0 = hs_cnt;
    set_req(3'd6, 0, 0, 1, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F);
    tick(); req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("macc1_stall", {m_valid, m_flush, uop, m_rs1, m_rs2, m_rs3},
          {2'b10, 9'b000000010, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F});
      tick();
    end
    chk("macc_mods_pw", {mods, pw}, {3'b000, 5'b10000});
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("macc2_stall", {m_valid, uop, m_rs1, m_rs3},
          {1'b1, 9'b000000001, 32'h1234_5678, 32'h0F0F_0F0F});
      tick();
    end
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("macc_rsp", {m_valid, rsp_valid, rsp_error}, 3'b010);
    chk("macc_result", rsp_result, 64'h0F0F_0F0F_1234_5678);
    chk("macc_hs_cnt", hs_cnt - h0, 2);

    // hold response for 5 cycles with a request pending
    set_req(3'd2, 0, 0, 0, 3'd0, 32'd3, 32'd5, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rsp", {rsp_valid, req_ready, rsp_error, rsp_result},
          {3'b100, 64'h0F0F_0F0F_1234_5678});
    end
    rsp_ready = 1'b1; m_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("hold_release", {rsp_valid, req_ready, m_valid}, 3'b010);
    tick(); req_valid = 1'b0;
    chk("hold_next_accept", {m_valid, uop}, {1'b1, 9'b001000000});
    tick();
    chk("hold_next_result", {rsp_valid, rsp_result}, {1'b1, 64'd15});
    drain();

    // illegal op 7
    h0 = hs_cnt;
    set_req(3'd7, 0, 0, 0, 3'd0, 32'd1, 32'd1, 32'd1);
    tick(); req_valid = 1'b0;
    chk("ill_op", {m_valid, rsp_valid, rsp_error, rsp_result}, {3'b011, 64'd0});
    drain();
    // pmul at width 32 is illegal
    set_req(3'd3, 0, 0, 0, 3'd0, 32'd1, 32'd1, 32'd1);
    tick(); req_valid = 1'b0;
    chk("ill_pmul_pw0", {m_valid, rsp_valid, rsp_error, rsp_result}, {3'b011, 64'd0});
    drain();
    // width code above 4 is illegal even for mul
    set_req(3'd2, 0, 0, 0, 3'd5, 32'd1, 32'd1, 32'd1);
    tick(); req_valid = 1'b0;
    chk("ill_pw5", {m_valid, rsp_valid, rsp_error}, 3'b011);
    drain();
    chk("ill_no_hs", hs_cnt - h0, 0);

    // legal pmul at width 8, carryless kept, signs cleared
    set_req(3'd3, 1, 1, 1, 3'd2, 32'd9, 32'd9, 32'd0);
    tick(); req_valid = 1'b0;
    chk("pmul_issue", {uop, mods, pw}, {9'b000100000, 3'b001, 5'b00100});
    tick();
    chk("pmul_result", {rsp_valid, rsp_error, rsp_result}, {2'b10, 64'h55});
    drain();

    // div: rh sign follows lh sign, carryless dropped
    set_req(3'd0, 1, 0, 1, 3'd0, 32'd100, 32'd7, 32'd0);
    tick(); req_valid = 1'b0;
    chk("div_issue", {uop, mods, pw}, {9'b100000000, 3'b110, 5'b10000});
    tick();
    chk("div_result", rsp_result, 64'd14);
    drain();

    // mul carryless forces lh sign low
    set_req(3'd2, 1, 0, 1, 3'd0, 32'd3, 32'd5, 32'd0);
    tick(); req_valid = 1'b0;
    chk("mulcl_mods", mods, 3'b001);
    tick(); drain();

    // reset while in ISSUE2 of msub
    set_req(3'd5, 0, 0, 0, 3'd0, 32'hCAFE_0000, 32'd1, 32'hBEEF_0000);
    tick(); req_valid = 1'b0;
    chk("msub_uop1", uop, 9'b000001000);
    tick();
    chk("msub_uop2", {m_valid, uop}, {1'b1, 9'b000000100});
    m_ready = 1'b0; reset = 1'b1;
    #1 chk("rst_mid_no_flush", m_flush, 0);
    tick();
    chk("rst_mid_outputs", {m_valid, rsp_valid, rsp_error, uop, mods, pw, m_rs1, req_ready},
        {3'b000, 9'b0, 3'b0, 5'b0, 32'h0, 1'b0});
    chk("rst_mid_result", rsp_result, 64'd0);
    reset = 1'b0; tick();
    chk("rst_mid_ready", {req_ready, rsp_valid}, 2'b10);
    m_ready = 1'b1;
    set_req(3'd2, 0, 0, 0, 3'd0, 32'd6, 32'd7, 32'd0);
    tick(); req_valid = 1'b0; tick();
    chk("post_rst_mul", {rsp_valid, rsp_error, rsp_result}, {2'b10, 64'd42});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
